// File: rtl/cnn_maxpool_ctrl_pkg.sv
// Shared types and constants for the 2x2/stride-2 max-pool sequencer.
package cnn_maxpool_ctrl_pkg;

    localparam int unsigned DW_DEFAULT = 16;
    // Registered latency of the external max-pool unit (mp_valid -> mp_out_valid).
    localparam int unsigned MP_LATENCY = 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    // A frame dimension is usable when it is non-zero, even and fits the buffers.
    function automatic logic dim_ok(input int unsigned dim, input int unsigned max_dim);
        return (dim != 0) && !dim[0] && (dim <= max_dim);
    endfunction

endpackage

// File: rtl/cnn_maxpool_ctrl_if.sv
// Pixel stream, max-pool unit and pooled-output signals of the sequencer.
// master: the sequencer side; slave: the surrounding stream/max-pool side.
interface cnn_maxpool_ctrl_if #(
    parameter int unsigned DW = 16
);
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] s_data;

    logic                 mp_valid;
    logic signed [DW-1:0] mp_in0;
    logic signed [DW-1:0] mp_in1;
    logic signed [DW-1:0] mp_in2;
    logic signed [DW-1:0] mp_in3;
    logic signed [DW-1:0] mp_out;
    logic                 mp_out_valid;

    logic                 m_valid;
    logic                 m_ready;
    logic signed [DW-1:0] m_data;

    modport master (
        input  s_valid, s_data, mp_out, mp_out_valid, m_ready,
        output s_ready, mp_valid, mp_in0, mp_in1, mp_in2, mp_in3, m_valid, m_data
    );

    modport slave (
        output s_valid, s_data, mp_out, mp_out_valid, m_ready,
        input  s_ready, mp_valid, mp_in0, mp_in1, mp_in2, mp_in3, m_valid, m_data
    );

endinterface

// File: rtl/cnn_maxpool_ctrl_line_buf.sv
// One-row line buffer: single write port, two asynchronous read ports.
module cnn_maxpool_ctrl_line_buf #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 416
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DW-1:0]            i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr0,
    input  logic [$clog2(DEPTH)-1:0] i_raddr1,
    output logic [DW-1:0]            o_rdata0,
    output logic [DW-1:0]            o_rdata1
);

    logic [DW-1:0] r_mem [DEPTH];

    // Storage write; contents need no reset since a row is always written before it is read.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/cnn_maxpool_ctrl.sv
// 2x2/stride-2 max-pool sequencer: row buffering, window issue, credit-guarded output FIFO.
module cnn_maxpool_ctrl
    import cnn_maxpool_ctrl_pkg::*;
#(
    parameter int unsigned DW         = DW_DEFAULT,
    parameter int unsigned MAX_W      = 416,
    parameter int unsigned MAX_H      = 416,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [$clog2(MAX_W+1)-1:0] cfg_width,
    input  logic [$clog2(MAX_H+1)-1:0] cfg_height,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err,
    cnn_maxpool_ctrl_if.master         bus
);

    localparam int unsigned WW = $clog2(MAX_W + 1);
    localparam int unsigned HW = $clog2(MAX_H + 1);
    localparam int unsigned AW = $clog2(MAX_W);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IW = $clog2(MP_LATENCY + 2);

    state_e               r_state;
    state_e               w_state_d;
    logic [WW-1:0]        r_width;
    logic [HW-1:0]        r_height;
    logic [WW-1:0]        r_col;
    logic [HW-1:0]        r_row;
    logic                 r_cfg_err;

    logic signed [DW-1:0] r_left;
    logic                 r_mp_valid;
    logic signed [DW-1:0] r_mp_in0;
    logic signed [DW-1:0] r_mp_in1;
    logic signed [DW-1:0] r_mp_in2;
    logic signed [DW-1:0] r_mp_in3;

    logic [IW-1:0]        r_inflight;
    logic signed [DW-1:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;

    logic                 w_cfg_ok;
    logic                 w_row_odd;
    logic                 w_is_window;
    logic                 w_credit_ok;
    logic                 w_s_ready;
    logic                 w_s_fire;
    logic                 w_col_last;
    logic                 w_row_last;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic [IW-1:0]        w_inflight_d;
    logic [CW-1:0]        w_count_d;
    logic [AW-1:0]        w_col_m1;
    logic [DW-1:0]        w_lb_rd0;
    logic [DW-1:0]        w_lb_rd1;

    assign w_cfg_ok    = dim_ok(32'(cfg_width), MAX_W) && dim_ok(32'(cfg_height), MAX_H);
    assign w_row_odd   = r_row[0];
    assign w_is_window = w_row_odd & r_col[0];
    // A window may only start if its result is guaranteed a FIFO slot on arrival.
    assign w_credit_ok = (32'(r_inflight) + 32'(r_count)) < FIFO_DEPTH;
    assign w_s_ready   = (r_state == StRun) && (!w_is_window || w_credit_ok);
    assign w_s_fire    = bus.s_valid && w_s_ready;
    assign w_col_last  = (r_col == r_width - WW'(1));
    assign w_row_last  = (r_row == r_height - HW'(1));
    assign w_issue     = w_s_fire && w_is_window;
    // Results with no window outstanding (e.g. launched before a reset) are dropped.
    assign w_push      = bus.mp_out_valid && (r_inflight != '0);
    assign w_pop       = (r_count != '0) && bus.m_ready;

    assign w_inflight_d = r_inflight + IW'(w_issue) - IW'(w_push);
    assign w_count_d    = r_count + CW'(w_push) - CW'(w_pop);
    assign w_col_m1     = r_col[AW-1:0] - AW'(1);

    cnn_maxpool_ctrl_line_buf #(
        .DW    (DW),
        .DEPTH (MAX_W)
    ) u_line_buf (
        .clk      (clk),
        .i_we     (w_s_fire && !w_row_odd),
        .i_waddr  (r_col[AW-1:0]),
        .i_wdata  (bus.s_data),
        .i_raddr0 (w_col_m1),
        .i_raddr1 (r_col[AW-1:0]),
        .o_rdata0 (w_lb_rd0),
        .o_rdata1 (w_lb_rd1)
    );

    // Next-state decode; DRAIN exits on the cycle the final result leaves.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (start) w_state_d = w_cfg_ok ? StRun : StDone;
            StRun:   if (w_s_fire && w_col_last && w_row_last) w_state_d = StDrain;
            StDrain: if ((w_count_d == '0) && (w_inflight_d == '0)) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // State, configuration latch and raster position counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_width   <= '0;
            r_height  <= '0;
            r_cfg_err <= 1'b0;
            r_col     <= '0;
            r_row     <= '0;
        end else begin
            r_state <= w_state_d;
            if ((r_state == StIdle) && start) begin
                r_cfg_err <= !w_cfg_ok;
                r_width   <= cfg_width;
                r_height  <= cfg_height;
                r_col     <= '0;
                r_row     <= '0;
            end else if (w_s_fire) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= r_row + HW'(1);
                end else begin
                    r_col <= r_col + WW'(1);
                end
            end
        end
    end

    // Left-pixel hold and registered window issue; mp_in* keep their last value when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_left     <= '0;
            r_mp_valid <= 1'b0;
            r_mp_in0   <= '0;
            r_mp_in1   <= '0;
            r_mp_in2   <= '0;
            r_mp_in3   <= '0;
        end else begin
            r_mp_valid <= w_issue;
            if (w_s_fire && w_row_odd && !r_col[0]) begin
                r_left <= bus.s_data;
            end
            if (w_issue) begin
                r_mp_in0 <= w_lb_rd0;
                r_mp_in1 <= w_lb_rd1;
                r_mp_in2 <= r_left;
                r_mp_in3 <= bus.s_data;
            end
        end
    end

    // Output FIFO and outstanding-window credit count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= bus.mp_out;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count    <= w_count_d;
            r_inflight <= w_inflight_d;
        end
    end

    assign busy         = (r_state == StRun) || (r_state == StDrain);
    assign done         = (r_state == StDone);
    assign cfg_err      = r_cfg_err;
    assign bus.s_ready  = w_s_ready;
    assign bus.mp_valid = r_mp_valid;
    assign bus.mp_in0   = r_mp_in0;
    assign bus.mp_in1   = r_mp_in1;
    assign bus.mp_in2   = r_mp_in2;
    assign bus.mp_in3   = r_mp_in3;
    assign bus.m_valid  = (r_count != '0);
    assign bus.m_data   = r_fifo[r_rd_ptr];

endmodule

// File: tb/tb_cnn_maxpool_ctrl.sv
// Self-checking bench for cnn_maxpool_ctrl with a behavioural 1-cycle max-pool unit.
module tb_cnn_maxpool_ctrl;

    localparam int DW     = 16;
    localparam int MAX_W  = 416;
    localparam int MAX_H  = 416;
    localparam int BUDGET = 20000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] cfg_width = '0;
    logic [8:0] cfg_height = '0;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int n_checks = 0;
    int n_err = 0;

    cnn_maxpool_ctrl_if #(.DW(DW)) bif ();

    cnn_maxpool_ctrl #(
        .DW         (DW),
        .MAX_W      (MAX_W),
        .MAX_H      (MAX_H),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .bus        (bif)
    );

    always #5 clk = ~clk;

    function automatic logic signed [DW-1:0] max4(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b,
                                                   input logic signed [DW-1:0] c,
                                                   input logic signed [DW-1:0] d);
        logic signed [DW-1:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Max-pool unit model: one registered stage.
    always @(posedge clk) begin
        bif.mp_out_valid <= bif.mp_valid;
        bif.mp_out       <= max4(bif.mp_in0, bif.mp_in1, bif.mp_in2, bif.mp_in3);
    end

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " cfg_err"}, cfg_err, 0);
        chk({tag, " s_ready"}, bif.s_ready, 0);
        chk({tag, " mp_valid"}, bif.mp_valid, 0);
        chk({tag, " mp_in0"}, bif.mp_in0, 0);
        chk({tag, " mp_in1"}, bif.mp_in1, 0);
        chk({tag, " mp_in2"}, bif.mp_in2, 0);
        chk({tag, " mp_in3"}, bif.mp_in3, 0);
        chk({tag, " m_valid"}, bif.m_valid, 0);
        chk({tag, " m_data"}, bif.m_data, 0);
    endtask

    // Runs one frame; exp_stall = first pixel index refused, -1 none, -2 not checked.
    task automatic run_frame(input string nm, input int w, input int h, input int px[$],
                             input int ex[$], input bit rnd, input int m_hold,
                             input int exp_stall);
        int   got[$];
        int   n_sent;
        int   stall_idx;
        logic done_seen;
        logic busy_seen;
        @(negedge clk);
        cfg_width  = 9'(w);
        cfg_height = 9'(h);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, " busy_after_start"}, busy, 1);
        chk({nm, " cfg_err_cleared"}, cfg_err, 0);
        n_sent    = 0;
        stall_idx = -1;
        done_seen = 1'b0;
        busy_seen = 1'b1;
        fork
            begin
                int cyc = 0;
                while (n_sent < px.size() && cyc < BUDGET) begin
                    bif.s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                    bif.s_data  = 16'(px[n_sent]);
                    #1;
                    if (bif.s_valid && !bif.s_ready && stall_idx < 0) stall_idx = n_sent;
                    if (bif.s_valid && bif.s_ready) n_sent++;
                    @(negedge clk);
                    cyc++;
                end
                bif.s_valid = 1'b0;
            end
            begin
                int cyc = 0;
                while (got.size() < ex.size() && cyc < BUDGET) begin
                    if (cyc < m_hold) bif.m_ready = 1'b0;
                    else bif.m_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
                    #1;
                    if (bif.m_valid && bif.m_ready) got.push_back(int'(bif.m_data));
                    @(negedge clk);
                    cyc++;
                end
                done_seen   = done;
                busy_seen   = busy;
                bif.m_ready = 1'b0;
            end
        join
        chk({nm, " pixels_accepted"}, n_sent, px.size());
        chk({nm, " out_count"}, got.size(), ex.size());
        for (int k = 0; k < ex.size() && k < got.size(); k++) begin
            chk($sformatf("%s out[%0d]", nm, k), got[k], ex[k]);
        end
        chk({nm, " done_after_last_out"}, done_seen, 1);
        chk({nm, " busy_low_at_done"}, busy_seen, 0);
        if (exp_stall != -2) chk({nm, " first_stall_idx"}, stall_idx, exp_stall);
        @(negedge clk);
        chk({nm, " done_one_cycle"}, done, 0);
    endtask

    typedef struct {
        int w;
        int h;
        int n_px;
        int px[20];
        int n_exp;
        int ex[5];
        int m_hold;
        int stall;
    } vec_t;

    vec_t tv[6];

    initial begin
        int pxq[$];
        int exq[$];
        int bad_w[3];
        int bad_h[3];
        logic signed [DW-1:0] v;

        bif.s_valid = 1'b0;
        bif.s_data  = '0;
        bif.m_ready = 1'b0;

        tv[0].w = 4; tv[0].h = 4; tv[0].n_px = 16; tv[0].n_exp = 4;
        tv[0].px = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 0, 0, 0, 0};
        tv[0].ex = '{6, 8, 14, 16, 0}; tv[0].m_hold = 0; tv[0].stall = -1;
        tv[1].w = 2; tv[1].h = 2; tv[1].n_px = 4; tv[1].n_exp = 1;
        tv[1].px = '{-5, -3, -8, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[1].ex = '{-1, 0, 0, 0, 0}; tv[1].m_hold = 0; tv[1].stall = -1;
        tv[2].w = 2; tv[2].h = 2; tv[2].n_px = 4; tv[2].n_exp = 1;
        tv[2].px = '{-32768, -32768, -32768, -32768, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[2].ex = '{-32768, 0, 0, 0, 0}; tv[2].m_hold = 0; tv[2].stall = -1;
        tv[3].w = 4; tv[3].h = 2; tv[3].n_px = 8; tv[3].n_exp = 2;
        tv[3].px = '{7, -2, 0, 3, 1, 9, -4, -6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[3].ex = '{9, 3, 0, 0, 0}; tv[3].m_hold = 0; tv[3].stall = -1;
        // FIFO fills exactly with the last window: no refusal.
        tv[4].w = 8; tv[4].h = 2; tv[4].n_px = 16; tv[4].n_exp = 4;
        tv[4].px = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 0, 0, 0};
        tv[4].ex = '{9, 11, 13, 15, 0}; tv[4].m_hold = 25; tv[4].stall = -1;
        // Fifth window is refused until downstream drains.
        tv[5].w = 10; tv[5].h = 2; tv[5].n_px = 20; tv[5].n_exp = 5;
        tv[5].px = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19};
        tv[5].ex = '{11, 13, 15, 17, 19}; tv[5].m_hold = 35; tv[5].stall = 19;

        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            pxq.delete();
            exq.delete();
            for (int i = 0; i < tv[t].n_px; i++) pxq.push_back(tv[t].px[i]);
            for (int i = 0; i < tv[t].n_exp; i++) exq.push_back(tv[t].ex[i]);
            run_frame($sformatf("vec%0d", t), tv[t].w, tv[t].h, pxq, exq, 1'b0,
                      tv[t].m_hold, tv[t].stall);
        end

        // Rejected configurations.
        bad_w = '{5, 0, 2};
        bad_h = '{4, 2, 3};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cfg_width   = 9'(bad_w[i]);
            cfg_height  = 9'(bad_h[i]);
            start       = 1'b1;
            bif.s_valid = 1'b1;
            bif.s_data  = 16'sd7;
            #1;
            chk($sformatf("bad%0d s_ready_idle", i), bif.s_ready, 0);
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("bad%0d done", i), done, 1);
            chk($sformatf("bad%0d cfg_err", i), cfg_err, 1);
            chk($sformatf("bad%0d busy", i), busy, 0);
            chk($sformatf("bad%0d s_ready", i), bif.s_ready, 0);
            @(negedge clk);
            chk($sformatf("bad%0d done_pulse", i), done, 0);
            chk($sformatf("bad%0d cfg_err_held", i), cfg_err, 1);
            chk($sformatf("bad%0d s_ready_after", i), bif.s_ready, 0);
            bif.s_valid = 1'b0;
        end

        // Reset in the middle of a 4x4 frame after 10 pixels, results left in the FIFO.
        @(negedge clk);
        cfg_width  = 9'd4;
        cfg_height = 9'd4;
        start      = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        bif.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bif.s_valid = 1'b1;
            bif.s_data  = 16'(i + 1);
            #1;
            chk($sformatf("midrst px%0d s_ready", i), bif.s_ready, 1);
            @(negedge clk);
        end
        bif.s_valid = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        chk_quiet("midrst");
        @(negedge clk);
        rst_n = 1'b1;

        // Clean 2x2 frame: exact issue/output latency; a start while busy is ignored.
        @(negedge clk);
        cfg_width  = 9'd2;
        cfg_height = 9'd2;
        start      = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            start       = (i == 1);
            cfg_width   = (i == 1) ? 9'd4 : 9'd2;
            bif.s_valid = 1'b1;
            bif.s_data  = 16'(i + 1);
            #1;
            chk($sformatf("lat px%0d s_ready", i), bif.s_ready, 1);
            @(negedge clk);
        end
        start       = 1'b0;
        bif.s_valid = 1'b0;
        chk("lat t+1 mp_valid", bif.mp_valid, 1);
        chk("lat mp_in0", bif.mp_in0, 1);
        chk("lat mp_in1", bif.mp_in1, 2);
        chk("lat mp_in2", bif.mp_in2, 3);
        chk("lat mp_in3", bif.mp_in3, 4);
        chk("lat s_ready_drain", bif.s_ready, 0);
        @(negedge clk);
        chk("lat t+2 mp_valid", bif.mp_valid, 0);
        chk("lat t+2 m_valid", bif.m_valid, 0);
        chk("lat t+2 mp_in3_held", bif.mp_in3, 4);
        @(negedge clk);
        chk("lat t+3 m_valid", bif.m_valid, 1);
        chk("lat t+3 m_data", bif.m_data, 4);
        bif.m_ready = 1'b1;
        @(negedge clk);
        bif.m_ready = 1'b0;
        chk("lat done", done, 1);
        chk("lat m_valid_empty", bif.m_valid, 0);
        @(negedge clk);
        chk("lat done_pulse", done, 0);
        chk("lat busy", busy, 0);

        // Full-width 4-row frame with random gaps on both sides against a golden model.
        pxq.delete();
        exq.delete();
        for (int i = 0; i < MAX_W * 4; i++) begin
            v = DW'($urandom);
            pxq.push_back(int'(v));
        end
        for (int r = 1; r < 4; r += 2) begin
            for (int c = 1; c < MAX_W; c += 2) begin
                exq.push_back(int'(max4(DW'(pxq[(r - 1) * MAX_W + c - 1]),
                                        DW'(pxq[(r - 1) * MAX_W + c]),
                                        DW'(pxq[r * MAX_W + c - 1]),
                                        DW'(pxq[r * MAX_W + c]))));
            end
        end
        run_frame("rand", MAX_W, 4, pxq, exq, 1'b1, 0, -2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
